// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types for the slave-arbiter write-data router
package sa_pkg;
  localparam int SA_MST_AMT  = 3;
  localparam int SA_DATA_W   = 32;
  localparam int SA_STRB_W   = SA_DATA_W / 8;
  localparam int SA_LEN_W    = 8;
  localparam int SA_MST_ID_W = (SA_MST_AMT > 1) ? $clog2(SA_MST_AMT) : 1;

  typedef struct packed {
    logic [SA_MST_ID_W-1:0] mst_id;
    logic [SA_LEN_W-1:0]    axlen;
  } order_t;

  typedef struct packed {
    logic [SA_DATA_W-1:0] data;
    logic [SA_STRB_W-1:0] strb;
    logic                 last;
  } beat_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wstate_e;
endpackage

// File: rtl/sa_wdata_router_if.sv
// rtl/sa_wdata_router_if.sv - slave-side W channel bundle
interface sa_wdata_router_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  modport master (output wdata, output wstrb, output wlast, output wvalid, input wready);
  modport slave  (input wdata, input wstrb, input wlast, input wvalid, output wready);
endinterface

// File: rtl/fifo.sv
// rtl/fifo.sv - generic first-word-fall-through FIFO, push and pop legal together at any occupancy
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_ptr_q];
  assign do_rd = rd_en & ~empty;
  // A pop frees the slot, so a push at full is accepted in the same cycle.
  assign do_wr = wr_en & (~full | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/sa_wdata_burst_ctrl.sv
// rtl/sa_wdata_burst_ctrl.sv - burst FSM, beat counter, WLAST check and slave output register
module sa_wdata_burst_ctrl
  import sa_pkg::*;
#(
  parameter int MST_AMT = SA_MST_AMT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  order_empty,
  input  order_t                order_rdata,
  output logic                  order_pop,
  input  logic [MST_AMT-1:0]    beat_empty,
  input  beat_t                 beat_rdata [MST_AMT],
  output logic [MST_AMT-1:0]    beat_pop,
  sa_wdata_router_if.master     s_w,
  output logic                  wlast_err
);
  wstate_e                state_q, state_d;
  logic [SA_MST_ID_W-1:0] cur_id_q, cur_id_d;
  logic [SA_LEN_W-1:0]    cur_len_q, cur_len_d;
  logic [SA_LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [SA_DATA_W-1:0]   wdata_q, wdata_d;
  logic [SA_STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                   wlast_q, wlast_d;
  logic                   wvalid_q, wvalid_d;
  logic                   err_q, err_d;

  logic                   in_burst, have_burst, ld, avail, is_last;
  logic [SA_MST_ID_W-1:0] act_id;
  logic [SA_LEN_W-1:0]    act_len, act_cnt;

  // In IDLE the head order entry is used directly, so a new burst forwards its first beat without a bubble.
  assign in_burst   = (state_q == ST_BURST);
  assign have_burst = in_burst | ~order_empty;
  assign act_id     = in_burst ? cur_id_q  : order_rdata.mst_id;
  assign act_len    = in_burst ? cur_len_q : order_rdata.axlen;
  assign act_cnt    = in_burst ? beat_cnt_q : '0;
  assign ld         = ~wvalid_q | s_w.wready;
  assign avail      = have_burst && (int'(act_id) < MST_AMT) && !beat_empty[act_id];
  assign is_last    = (act_cnt == act_len);

  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    cur_len_d  = cur_len_q;
    beat_cnt_d = beat_cnt_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wlast_d    = wlast_q;
    wvalid_d   = wvalid_q;
    err_d      = err_q;
    order_pop  = 1'b0;
    beat_pop   = '0;

    if (!in_burst && !order_empty) begin
      order_pop  = 1'b1;
      state_d    = ST_BURST;
      cur_id_d   = order_rdata.mst_id;
      cur_len_d  = order_rdata.axlen;
      beat_cnt_d = '0;
    end

    if (ld) begin
      if (avail) begin
        beat_pop[act_id] = 1'b1;
        wdata_d  = beat_rdata[act_id].data;
        wstrb_d  = beat_rdata[act_id].strb;
        wlast_d  = is_last;
        wvalid_d = 1'b1;
        if (beat_rdata[act_id].last != is_last) err_d = 1'b1;
        if (is_last) begin
          beat_cnt_d = '0;
          // The order entry was already popped this cycle when the burst started from IDLE.
          if (in_burst && !order_empty) begin
            order_pop = 1'b1;
            cur_id_d  = order_rdata.mst_id;
            cur_len_d = order_rdata.axlen;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          beat_cnt_d = act_cnt + 1'b1;
        end
      end else begin
        wvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cur_id_q   <= '0;
      cur_len_q  <= '0;
      beat_cnt_q <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wlast_q    <= 1'b0;
      wvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      cur_len_q  <= cur_len_d;
      beat_cnt_q <= beat_cnt_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wlast_q    <= wlast_d;
      wvalid_q   <= wvalid_d;
      err_q      <= err_d;
    end
  end

  assign s_w.wdata  = wdata_q;
  assign s_w.wstrb  = wstrb_q;
  assign s_w.wlast  = wlast_q;
  assign s_w.wvalid = wvalid_q;
  assign wlast_err  = err_q;
endmodule

// File: rtl/sa_wdata_router.sv
// rtl/sa_wdata_router.sv - per-master W beat buffering forwarded to one slave in AW order
module sa_wdata_router
  import sa_pkg::*;
#(
  parameter int MST_AMT          = SA_MST_AMT,
  parameter int OUTSTANDING_AMT  = 8,
  parameter int WDATA_FIFO_DEPTH = 16,
  parameter int DATA_WIDTH       = SA_DATA_W,
  parameter int TRANS_DATA_LEN_W = SA_LEN_W,
  parameter int MST_ID_W         = SA_MST_ID_W
) (
  input  logic                            ACLK_i,
  input  logic                            ARESETn_i,
  input  logic [DATA_WIDTH*MST_AMT-1:0]   dsp_WDATA_i,
  input  logic [DATA_WIDTH/8*MST_AMT-1:0] dsp_WSTRB_i,
  input  logic [MST_AMT-1:0]              dsp_WLAST_i,
  input  logic [MST_AMT-1:0]              dsp_WVALID_i,
  input  logic [MST_AMT-1:0]              dsp_slv_sel_i,
  output logic [MST_AMT-1:0]              dsp_WREADY_o,
  input  logic [MST_ID_W-1:0]             AW_mst_id_i,
  input  logic [TRANS_DATA_LEN_W-1:0]     AW_AxLEN_i,
  input  logic                            AW_fifo_order_wr_en_i,
  output logic                            AW_stall_o,
  output logic [DATA_WIDTH-1:0]           s_WDATA_o,
  output logic [DATA_WIDTH/8-1:0]         s_WSTRB_o,
  output logic                            s_WLAST_o,
  output logic                            s_WVALID_o,
  input  logic                            s_WREADY_i,
  output logic                            wlast_err_o
);
  localparam int STRB_W = DATA_WIDTH / 8;

  order_t               order_wdata, order_rdata;
  logic                 order_pop, order_empty;
  beat_t                beat_wdata [MST_AMT];
  beat_t                beat_rdata [MST_AMT];
  logic [MST_AMT-1:0]   beat_push, beat_pop, beat_full, beat_empty;

  sa_wdata_router_if #(.DATA_WIDTH(DATA_WIDTH)) s_w ();

  assign order_wdata.mst_id = AW_mst_id_i;
  assign order_wdata.axlen  = AW_AxLEN_i;

  fifo #(.WIDTH($bits(order_t)), .DEPTH(OUTSTANDING_AMT)) u_order_fifo (
    .clk    (ACLK_i),
    .resetn (ARESETn_i),
    .wr_en  (AW_fifo_order_wr_en_i),
    .wdata  (order_wdata),
    .rd_en  (order_pop),
    .rdata  (order_rdata),
    .full   (AW_stall_o),
    .empty  (order_empty)
  );

  for (genvar m = 0; m < MST_AMT; m++) begin : g_beat
    assign beat_wdata[m].data = dsp_WDATA_i[m*DATA_WIDTH +: DATA_WIDTH];
    assign beat_wdata[m].strb = dsp_WSTRB_i[m*STRB_W +: STRB_W];
    assign beat_wdata[m].last = dsp_WLAST_i[m];
    assign beat_push[m]       = dsp_WVALID_i[m] & dsp_slv_sel_i[m] & ~beat_full[m];

    fifo #(.WIDTH($bits(beat_t)), .DEPTH(WDATA_FIFO_DEPTH)) u_beat_fifo (
      .clk    (ACLK_i),
      .resetn (ARESETn_i),
      .wr_en  (beat_push[m]),
      .wdata  (beat_wdata[m]),
      .rd_en  (beat_pop[m]),
      .rdata  (beat_rdata[m]),
      .full   (beat_full[m]),
      .empty  (beat_empty[m])
    );
  end

  assign dsp_WREADY_o = ~beat_full;

  sa_wdata_burst_ctrl #(.MST_AMT(MST_AMT)) u_burst_ctrl (
    .clk         (ACLK_i),
    .resetn      (ARESETn_i),
    .order_empty (order_empty),
    .order_rdata (order_rdata),
    .order_pop   (order_pop),
    .beat_empty  (beat_empty),
    .beat_rdata  (beat_rdata),
    .beat_pop    (beat_pop),
    .s_w         (s_w),
    .wlast_err   (wlast_err_o)
  );

  assign s_w.wready = s_WREADY_i;
  assign s_WDATA_o  = s_w.wdata;
  assign s_WSTRB_o  = s_w.wstrb;
  assign s_WLAST_o  = s_w.wlast;
  assign s_WVALID_o = s_w.wvalid;
endmodule
